// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared definitions for the two-port RAM arbiter.
//   - ADDR_W_DEF / DATA_W_DEF : default RAM geometry (32 x 32)
//   - state_t + StIdle/StCmd/StResp : sequencer state encoding
//   - REQ0 / REQ1             : requester index constants
package ram_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 32;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StCmd  = 2'd1;
    localparam state_t StResp = 2'd2;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: one requester's command/response channel.
//   req/we/addr/wdata : command, held by the requester until gnt
//   gnt               : one-cycle pulse, command accepted
//   done              : one-cycle pulse, access complete
//   rdata             : read data, valid in the done cycle of a read
// master = requester side, slave = arbiter side.
interface ram_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              done;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, done, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, done, rdata
    );
endinterface

// File: rtl/ram_arbiter_rr_pick2.sv
// rr_pick2: combinational 2-way round-robin picker.
//   req0_i, req1_i : pending requests
//   last_i         : index of the previous winner
//   valid_o        : at least one request pending
//   winner_o       : chosen index (the one that did not win last on a tie)
module rr_pick2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic valid_o,
    output logic winner_o
);
    always_comb begin
        valid_o = req0_i | req1_i;
        if (req0_i && req1_i) begin
            winner_o = ~last_i;
        end else begin
            winner_o = req1_i;
        end
    end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter and sequencer in front of a single-port
// synchronous RAM. One access in flight at a time: IDLE (arbitrate) ->
// CMD (RAM strobed) -> RESP (read data on ram_dout_i) -> IDLE (done pulse).
//   clk, rst_n        : clock, async active-low reset
//   req0_if, req1_if  : requester channels (slave side)
//   busy_o            : sequencer not idle
//   ram_cen_o/wen_o/addr_o/din_o : registered RAM controls
//   ram_dout_i        : RAM read data, valid the cycle after a read strobe
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_arbiter_if.slave      req0_if,
    ram_arbiter_if.slave      req1_if,
    output logic              busy_o,
    output logic              ram_cen_o,
    output logic              ram_wen_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_din_o,
    input  logic [DATA_W-1:0] ram_dout_i
);
    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              rd_flag_q, rd_flag_d;
    logic              owner_q, owner_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        done_q, done_d;
    logic              cen_q, cen_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic              pick_valid;
    logic              pick_winner;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    rr_pick2 u_pick (
        .req0_i   (req0_if.req),
        .req1_i   (req1_if.req),
        .last_i   (last_q),
        .valid_o  (pick_valid),
        .winner_o (pick_winner)
    );

    // Command fields of the winning requester.
    always_comb begin
        if (pick_winner == REQ1) begin
            win_we    = req1_if.we;
            win_addr  = req1_if.addr;
            win_wdata = req1_if.wdata;
        end else begin
            win_we    = req0_if.we;
            win_addr  = req0_if.addr;
            win_wdata = req0_if.wdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        rd_flag_d = rd_flag_q;
        owner_d   = owner_q;
        gnt_d     = 2'b00;
        done_d    = 2'b00;
        cen_d     = cen_q;
        wen_d     = wen_q;
        addr_d    = addr_q;
        din_d     = din_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;

        case (state_q)
            StIdle: begin
                cen_d = 1'b0;
                if (pick_valid) begin
                    gnt_d[pick_winner] = 1'b1;
                    cen_d              = 1'b1;
                    wen_d              = win_we;
                    addr_d             = win_addr;
                    din_d              = win_wdata;
                    owner_d            = pick_winner;
                    last_d             = pick_winner;
                    rd_flag_d          = ~win_we;
                    state_d            = StCmd;
                end
            end
            StCmd: begin
                // RAM samples the strobe at this closing edge.
                cen_d   = 1'b0;
                wen_d   = 1'b0;
                state_d = StResp;
            end
            StResp: begin
                done_d[owner_q] = 1'b1;
                if (rd_flag_q) begin
                    if (owner_q == REQ1) begin
                        rdata1_d = ram_dout_i;
                    end else begin
                        rdata0_d = ram_dout_i;
                    end
                end
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            last_q    <= REQ1;  // requester 0 wins the first tie
            rd_flag_q <= 1'b0;
            owner_q   <= REQ0;
            gnt_q     <= 2'b00;
            done_q    <= 2'b00;
            cen_q     <= 1'b0;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            rd_flag_q <= rd_flag_d;
            owner_q   <= owner_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            cen_q     <= cen_d;
            wen_q     <= wen_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign req0_if.gnt   = gnt_q[REQ0];
    assign req1_if.gnt   = gnt_q[REQ1];
    assign req0_if.done  = done_q[REQ0];
    assign req1_if.done  = done_q[REQ1];
    assign req0_if.rdata = rdata0_q;
    assign req1_if.rdata = rdata1_q;
    assign busy_o        = (state_q != StIdle);
    assign ram_cen_o     = cen_q;
    assign ram_wen_o     = wen_q;
    assign ram_addr_o    = addr_q;
    assign ram_din_o     = din_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model of the arbiter and its RAM.
module tb_ram_arbiter;
    logic        clk;
    logic        rst_n;
    logic        busy;
    logic        ram_cen;
    logic        ram_wen;
    logic [4:0]  ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    ram_arbiter_if #(.ADDR_W(5), .DATA_W(32)) r0 ();
    ram_arbiter_if #(.ADDR_W(5), .DATA_W(32)) r1 ();

    ram_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_if    (r0),
        .req1_if    (r1),
        .busy_o     (busy),
        .ram_cen_o  (ram_cen),
        .ram_wen_o  (ram_wen),
        .ram_addr_o (ram_addr),
        .ram_din_o  (ram_din),
        .ram_dout_i (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment RAM (not reset).
    logic [31:0] ram_mem [32];
    always @(posedge clk) begin
        if (ram_cen) begin
            if (ram_wen) ram_mem[ram_addr] <= ram_din;
            else         ram_dout <= ram_mem[ram_addr];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // A granted access occupies edges g (grant), g+1 (RAM access), g+2 (done);
    // the next arbitration is possible at edge g+3.
    int          m_e;
    int          m_g;
    bit          m_busy;
    bit          m_last;
    bit          m_who;
    bit          m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rd;
    logic [31:0] mdl_mem [32];
    logic [31:0] mdl_rdata [2];
    logic [1:0]  e_gnt, e_done;
    logic        e_busy, e_cen, e_wen;
    logic [4:0]  e_addr;
    logic [31:0] e_din;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_e = 0; m_g = 0; m_busy = 0; m_last = 1; m_rd = 0;
            e_gnt = 0; e_done = 0; e_busy = 0; e_cen = 0; e_wen = 0;
            e_addr = 0; e_din = 0;
            mdl_rdata[0] = 0; mdl_rdata[1] = 0;
        end else begin
            m_e++;
            e_gnt = 0; e_done = 0; e_cen = 0; e_wen = 0;
            if (m_busy && m_e == m_g + 1) begin
                if (m_we) mdl_mem[m_addr] = m_wdata;
                else      m_rd = mdl_mem[m_addr];
            end
            if (m_busy && m_e == m_g + 2) begin
                e_done[m_who] = 1'b1;
                if (!m_we) mdl_rdata[m_who] = m_rd;
                m_busy = 0;
            end else if (!m_busy && (r0.req || r1.req)) begin
                // Tie goes to whoever did not win last.
                if (r0.req && r1.req) m_who = !m_last;
                else                  m_who = r1.req;
                m_we    = m_who ? r1.we : r0.we;
                m_addr  = m_who ? r1.addr : r0.addr;
                m_wdata = m_who ? r1.wdata : r0.wdata;
                m_last  = m_who;
                m_g     = m_e;
                m_busy  = 1;
                e_gnt[m_who] = 1'b1;
                e_cen  = 1'b1;
                e_wen  = m_we;
                e_addr = m_addr;
                e_din  = m_wdata;
            end
            e_busy = m_busy;
        end
    end

    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("gnt0", 32'(r0.gnt), 32'(e_gnt[0]));
            chk("gnt1", 32'(r1.gnt), 32'(e_gnt[1]));
            chk("done0", 32'(r0.done), 32'(e_done[0]));
            chk("done1", 32'(r1.done), 32'(e_done[1]));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("ram_cen", 32'(ram_cen), 32'(e_cen));
            chk("ram_wen", 32'(ram_wen), 32'(e_wen));
            chk("ram_addr", 32'(ram_addr), 32'(e_addr));
            chk("ram_din", ram_din, e_din);
            chk("rdata0", r0.rdata, mdl_rdata[0]);
            chk("rdata1", r1.rdata, mdl_rdata[1]);
            chk("gnt_excl", 32'(r0.gnt & r1.gnt), 32'd0);
            chk("done_excl", 32'(r0.done & r1.done), 32'd0);
        end
    end

    // Grant monitor for the fairness scenario.
    bit mon_en = 0;
    int ncyc = 0;
    int gq_who[$];
    int gq_cyc[$];
    always @(negedge clk) begin
        ncyc++;
        if (mon_en) begin
            if (r0.gnt) begin gq_who.push_back(0); gq_cyc.push_back(ncyc); end
            if (r1.gnt) begin gq_who.push_back(1); gq_cyc.push_back(ncyc); end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check_zero(input string tag);
        chk({tag, "_gnt"}, 32'({r1.gnt, r0.gnt}), 32'd0);
        chk({tag, "_done"}, 32'({r1.done, r0.done}), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_cen"}, 32'(ram_cen), 32'd0);
        chk({tag, "_wen"}, 32'(ram_wen), 32'd0);
        chk({tag, "_addr"}, 32'(ram_addr), 32'd0);
        chk({tag, "_din"}, ram_din, 32'd0);
        chk({tag, "_rdata0"}, r0.rdata, 32'd0);
        chk({tag, "_rdata1"}, r1.rdata, 32'd0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_cmd(input bit who, input bit rq, input bit we,
                           input logic [4:0] a, input logic [31:0] d);
        if (who) begin r1.req = rq; r1.we = we; r1.addr = a; r1.wdata = d; end
        else     begin r0.req = rq; r0.we = we; r0.addr = a; r0.wdata = d; end
    endtask

    // Single access from an idle arbiter with literal timing expectations.
    task automatic issue(input bit who, input bit we, input logic [4:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rdata);
        @(negedge clk);
        set_cmd(who, 1'b1, we, a, d);
        @(posedge clk);
        #1;
        chk("issue_gnt", 32'(who ? r1.gnt : r0.gnt), 32'd1);
        chk("issue_cen", 32'(ram_cen), 32'd1);
        chk("issue_wen", 32'(ram_wen), 32'(we));
        chk("issue_addr", 32'(ram_addr), 32'(a));
        chk("issue_din", ram_din, d);
        @(negedge clk);
        set_cmd(who, 1'b0, 1'b0, 5'd0, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("issue_done", 32'(who ? r1.done : r0.done), 32'd1);
        chk("issue_rdata", who ? r1.rdata : r0.rdata, exp_rdata);
    endtask

    task automatic rand_drive(input bit who);
        logic g, r;
        g = who ? r1.gnt : r0.gnt;
        r = who ? r1.req : r0.req;
        // Fields may only change once the current command is granted.
        if (!r || g) begin
            set_cmd(who, ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 31)), $urandom);
        end
    endtask

    logic [31:0] sval [3];

    initial begin
        for (int i = 0; i < 32; i++) begin
            ram_mem[i] = 32'd0;
            mdl_mem[i] = 32'd0;
        end
        ram_dout = 32'd0;
        sval[0] = 32'hCAFE0000;
        sval[1] = 32'h0BAD0001;
        sval[2] = 32'h5EED0002;
        set_cmd(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        set_cmd(1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_zero("por");
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1;

        // Write then read back through the other requester.
        issue(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0);
        issue(1'b1, 1'b0, 5'd5, 32'h0, 32'hDEADBEEF);
        chk("model_rdata1", mdl_rdata[1], 32'hDEADBEEF);

        // Fairness: both held, last winner was 1 so order is 0,1,0,1.
        @(negedge clk);
        set_cmd(1'b0, 1'b1, 1'b0, 5'd5, 32'h0);
        set_cmd(1'b1, 1'b1, 1'b0, 5'd5, 32'h0);
        mon_en = 1;
        repeat (11) @(negedge clk);
        set_cmd(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        set_cmd(1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        mon_en = 0;
        repeat (3) @(negedge clk);
        chk("fair_count", 32'(gq_who.size()), 32'd4);
        if (gq_who.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("fair_order", 32'(gq_who[i]), 32'(i % 2));
                if (i > 0) chk("fair_spacing", 32'(gq_cyc[i] - gq_cyc[i-1]), 32'd3);
            end
        end

        // Mid-run reset, then first tie after reset goes to requester 0.
        reset_pulse();
        @(negedge clk);
        set_cmd(1'b0, 1'b1, 1'b0, 5'd1, 32'h0);
        set_cmd(1'b1, 1'b1, 1'b0, 5'd2, 32'h0);
        @(posedge clk);
        #1;
        chk("tie_gnt0", 32'(r0.gnt), 32'd1);
        chk("tie_gnt1", 32'(r1.gnt), 32'd0);
        @(negedge clk);
        set_cmd(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        set_cmd(1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        repeat (3) @(negedge clk);

        // Unwritten location reads as zero.
        issue(1'b1, 1'b0, 5'd31, 32'h0, 32'h0);

        // Reset while the write strobe is up: access must not happen.
        @(negedge clk);
        set_cmd(1'b0, 1'b1, 1'b1, 5'd7, 32'h12345678);
        @(posedge clk);
        #1;
        chk("cmdrst_cen", 32'(ram_cen), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_zero("cmdrst");
        set_cmd(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("cmdrst_nodone", 32'(r0.done), 32'd0);
        end
        chk("model_mem7", mdl_mem[7], 32'h0);
        issue(1'b0, 1'b0, 5'd7, 32'h0, 32'h0);

        // Streaming reads from requester 0.
        for (int i = 0; i < 3; i++) issue(1'b0, 1'b1, 5'(i), sval[i], 32'h0);
        @(negedge clk);
        set_cmd(1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 chk("stream_gnt", 32'(r0.gnt), 32'd1);
            @(negedge clk);
            if (i < 2) r0.addr = 5'(i + 1);
            else       r0.req = 1'b0;
            @(posedge clk);
            @(posedge clk);
            #1;
            chk("stream_done", 32'(r0.done), 32'd1);
            chk("stream_rdata", r0.rdata, sval[i]);
        end

        // Random traffic from both requesters.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            rand_drive(1'b0);
            rand_drive(1'b1);
        end
        @(negedge clk);
        set_cmd(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        set_cmd(1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        repeat (6) @(negedge clk);
        cmp_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
